tag_slot_sequencer: RTL and testbench



---
 rtl/tag_slot_sequencer_pkg.sv | 9 +
 rtl/tag_slot_sequencer_if.sv | 25 ++
 rtl/tag_slot_sequencer_holdoff_timer.sv | 29 ++
 rtl/tag_slot_sequencer.sv | 81 ++++++++
 tb/tb_tag_slot_sequencer.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/tag_slot_sequencer_pkg.sv
// tag_slot_sequencer_pkg: slot geometry and FSM encoding shared by the time-tagging capture path
package tag_slot_sequencer_pkg;
    localparam int SLOT_N = 4;
    localparam int SLOT_W = 2;
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/tag_slot_sequencer_if.sv
// tag_slot_sequencer_if: trigger/readout bus between the sequencer and its environment
interface tag_slot_sequencer_if #(
    parameter int OVF_W = 16
);
    import tag_slot_sequencer_pkg::*;
    logic              trig_in;
    logic              rd_ack;
    logic              ovf_clr;
    logic [SLOT_W-1:0] slot_sel;
    logic              slot_valid;
    logic [SLOT_W-1:0] rd_slot;
    logic              rd_valid;
    logic              full;
    logic [2:0]        occupancy;
    logic              busy;
    logic [OVF_W-1:0]  ovf_cnt;
    modport master (
        output trig_in, rd_ack, ovf_clr,
        input  slot_sel, slot_valid, rd_slot, rd_valid, full, occupancy, busy, ovf_cnt
    );
    modport slave (
        input  trig_in, rd_ack, ovf_clr,
        output slot_sel, slot_valid, rd_slot, rd_valid, full, occupancy, busy, ovf_cnt
    );
endinterface

// File: rtl/tag_slot_sequencer_holdoff_timer.sv
// tag_holdoff_timer: dead-time down-counter, busy for HOLDOFF cycles after start
module tag_holdoff_timer #(
    parameter int HOLDOFF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic last
);
    localparam int CW = HOLDOFF > 0 ? $clog2(HOLDOFF + 1) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    always_comb begin
        cnt_d  = start ? CW'(HOLDOFF) : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        busy_d = cnt_d != '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
    assign busy = busy_q;
    assign last = cnt_q == CW'(1);
endmodule

// File: rtl/tag_slot_sequencer.sv
// tag_slot_sequencer: round-robin assignment of trigger edges to four capture slots with in-order readout
module tag_slot_sequencer
    import tag_slot_sequencer_pkg::*;
#(
    parameter int HOLDOFF = 4,
    parameter int OVF_W   = 16
) (
    input  logic clk,
    input  logic reset,
    tag_slot_sequencer_if.slave bus
);
    state_t            state_q, state_d;
    logic              trig_q;
    logic [SLOT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SLOT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [SLOT_W-1:0] slot_sel_q, slot_sel_d;
    logic              slot_valid_q, slot_valid_d;
    logic [2:0]        occ_q, occ_d;
    logic              full_q, full_d;
    logic              rd_valid_q, rd_valid_d;
    logic [OVF_W-1:0]  ovf_q, ovf_d;
    logic              trig_edge, accept, lost, ack, hold_busy, hold_last;
    tag_holdoff_timer #(.HOLDOFF(HOLDOFF)) u_holdoff (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .busy  (hold_busy),
        .last  (hold_last)
    );
    // full is the registered value, so an ack in the same cycle cannot make room
    always_comb begin
        trig_edge    = bus.trig_in & ~trig_q;
        accept       = trig_edge & (state_q == IDLE) & ~full_q;
        lost         = trig_edge & ~accept;
        ack          = bus.rd_ack & rd_valid_q;
        state_d      = (state_q == IDLE) ? ((accept && HOLDOFF > 0) ? HOLD : IDLE)
                                         : (hold_last ? IDLE : HOLD);
        wr_ptr_d     = wr_ptr_q + SLOT_W'(accept);
        rd_ptr_d     = rd_ptr_q + SLOT_W'(ack);
        slot_sel_d   = accept ? wr_ptr_q : slot_sel_q;
        slot_valid_d = accept;
        occ_d        = occ_q + 3'(accept) - 3'(ack);
        full_d       = occ_d == 3'(SLOT_N);
        rd_valid_d   = occ_d != 3'd0;
        ovf_d        = bus.ovf_clr ? OVF_W'(lost)
                     : (lost && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            trig_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            slot_sel_q   <= '0;
            slot_valid_q <= 1'b0;
            occ_q        <= '0;
            full_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            ovf_q        <= '0;
        end else begin
            state_q      <= state_d;
            trig_q       <= bus.trig_in;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            slot_sel_q   <= slot_sel_d;
            slot_valid_q <= slot_valid_d;
            occ_q        <= occ_d;
            full_q       <= full_d;
            rd_valid_q   <= rd_valid_d;
            ovf_q        <= ovf_d;
        end
    end
    assign bus.slot_sel   = slot_sel_q;
    assign bus.slot_valid = slot_valid_q;
    assign bus.rd_slot    = rd_ptr_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.full       = full_q;
    assign bus.occupancy  = occ_q;
    assign bus.busy       = hold_busy;
    assign bus.ovf_cnt    = ovf_q;
endmodule

// File: tb/tb_tag_slot_sequencer.sv
// tb_tag_slot_sequencer: vector table through a scoreboard queue plus reset and saturation sequences
module tb_tag_slot_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    tag_slot_sequencer_if #(.OVF_W(16)) a_if ();
    tag_slot_sequencer_if #(.OVF_W(2))  b_if ();
    tag_slot_sequencer #(.HOLDOFF(4), .OVF_W(16)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
    tag_slot_sequencer #(.HOLDOFF(0), .OVF_W(2))  dut_b (.clk(clk), .reset(reset), .bus(b_if));
    typedef struct {
        logic        t, a, c;
        logic [1:0]  sel;
        logic        sv;
        logic [2:0]  occ;
        logic        full, busy;
        logic [15:0] ovf;
        logic [1:0]  rds;
        logic        rdv;
    } vec_t;
    vec_t tbl[$];
    vec_t exp_q[$];
    task automatic add(int n, logic t, logic a, logic c, logic [1:0] sel, logic sv, logic [2:0] occ,
                       logic full, logic busy, logic [15:0] ovf, logic [1:0] rds, logic rdv);
        vec_t v;
        v.t = t; v.a = a; v.c = c; v.sel = sel; v.sv = sv; v.occ = occ;
        v.full = full; v.busy = busy; v.ovf = ovf; v.rds = rds; v.rdv = rdv;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask
    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic chk_a(string p, vec_t e);
        chk({p, " slot_sel"},   16'(a_if.slot_sel),   16'(e.sel));
        chk({p, " slot_valid"}, 16'(a_if.slot_valid), 16'(e.sv));
        chk({p, " occupancy"},  16'(a_if.occupancy),  16'(e.occ));
        chk({p, " full"},       16'(a_if.full),       16'(e.full));
        chk({p, " busy"},       16'(a_if.busy),       16'(e.busy));
        chk({p, " ovf_cnt"},    a_if.ovf_cnt,         e.ovf);
        chk({p, " rd_slot"},    16'(a_if.rd_slot),    16'(e.rds));
        chk({p, " rd_valid"},   16'(a_if.rd_valid),   16'(e.rdv));
    endtask
    initial begin
        vec_t e;
        a_if.trig_in = 0; a_if.rd_ack = 0; a_if.ovf_clr = 0;
        b_if.trig_in = 0; b_if.rd_ack = 0; b_if.ovf_clr = 0;
        //  n  t a c  sel sv occ full busy ovf rds rdv
        add(1, 0,0,0, 0,0,0,0,0, 0,0,0);
        add(1, 1,0,0, 0,1,1,0,1, 0,0,1);
        add(3, 0,0,0, 0,0,1,0,1, 0,0,1);
        add(1, 0,0,0, 0,0,1,0,0, 0,0,1);
        add(1, 1,0,0, 1,1,2,0,1, 0,0,1);
        add(3, 0,0,0, 1,0,2,0,1, 0,0,1);
        add(1, 0,0,0, 1,0,2,0,0, 0,0,1);
        add(1, 1,0,0, 2,1,3,0,1, 0,0,1);
        add(3, 0,0,0, 2,0,3,0,1, 0,0,1);
        add(1, 0,0,0, 2,0,3,0,0, 0,0,1);
        add(1, 1,0,0, 3,1,4,1,1, 0,0,1);
        add(3, 0,0,0, 3,0,4,1,1, 0,0,1);
        add(1, 0,0,0, 3,0,4,1,0, 0,0,1);
        add(1, 1,0,0, 3,0,4,1,0, 1,0,1);
        add(1, 0,0,0, 3,0,4,1,0, 1,0,1);
        add(1, 1,1,0, 3,0,3,0,0, 2,1,1);
        add(1, 0,0,0, 3,0,3,0,0, 2,1,1);
        add(1, 1,0,0, 0,1,4,1,1, 2,1,1);
        add(1, 0,1,0, 0,0,3,0,1, 2,2,1);
        add(1, 0,1,0, 0,0,2,0,1, 2,3,1);
        add(1, 0,0,0, 0,0,2,0,1, 2,3,1);
        add(1, 0,0,0, 0,0,2,0,0, 2,3,1);
        add(1, 1,1,0, 1,1,2,0,1, 2,0,1);
        add(1, 0,0,0, 1,0,2,0,1, 2,0,1);
        add(1, 0,1,0, 1,0,1,0,1, 2,1,1);
        add(1, 0,1,0, 1,0,0,0,1, 2,2,0);
        add(1, 0,1,0, 1,0,0,0,0, 2,2,0);
        add(1, 1,0,0, 2,1,1,0,1, 2,2,1);
        add(2, 0,0,0, 2,0,1,0,1, 2,2,1);
        add(1, 1,0,0, 2,0,1,0,1, 3,2,1);
        add(2, 0,0,0, 2,0,1,0,0, 3,2,1);
        add(1, 1,0,0, 3,1,2,0,1, 3,2,1);
        add(2, 0,0,0, 3,0,2,0,1, 3,2,1);
        add(1, 1,0,0, 3,0,2,0,1, 4,2,1);
        add(1, 0,0,0, 3,0,2,0,0, 4,2,1);
        add(1, 0,0,1, 3,0,2,0,0, 0,2,1);
        add(1, 1,0,0, 0,1,3,0,1, 0,2,1);
        add(1, 0,0,0, 0,0,3,0,1, 0,2,1);
        add(1, 1,0,1, 0,0,3,0,1, 1,2,1);
        add(1, 0,0,0, 0,0,3,0,1, 1,2,1);
        add(1, 0,0,0, 0,0,3,0,0, 1,2,1);
        repeat (3) @(posedge clk);
        #1;
        e = tbl[0];
        chk_a("in_reset", e);
        @(negedge clk);
        reset = 0;
        repeat (9) @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            a_if.trig_in = tbl[i].t;
            a_if.rd_ack  = tbl[i].a;
            a_if.ovf_clr = tbl[i].c;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk_a($sformatf("c%0d", i), e);
        end
        @(negedge clk);
        a_if.trig_in = 1; a_if.rd_ack = 0; a_if.ovf_clr = 0;
        @(negedge clk);
        chk("pre_reset busy", 16'(a_if.busy), 16'd1);
        chk("pre_reset occupancy", 16'(a_if.occupancy), 16'd4);
        reset = 1;
        #1;
        e = tbl[0];
        chk_a("async_reset", e);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        chk("release_edge slot_valid", 16'(a_if.slot_valid), 16'd1);
        chk("release_edge slot_sel", 16'(a_if.slot_sel), 16'd0);
        chk("release_edge occupancy", 16'(a_if.occupancy), 16'd1);
        chk("release_edge busy", 16'(a_if.busy), 16'd1);
        a_if.trig_in = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            b_if.trig_in = 1;
            @(negedge clk);
            b_if.trig_in = 0;
            chk($sformatf("b%0d occupancy", i), 16'(b_if.occupancy), 16'(i < 4 ? i + 1 : 4));
            chk($sformatf("b%0d ovf_cnt", i), 16'(b_if.ovf_cnt), 16'(i < 4 ? 0 : (i - 3 > 3 ? 3 : i - 3)));
            chk($sformatf("b%0d busy", i), 16'(b_if.busy), 16'd0);
        end
        @(negedge clk);
        b_if.trig_in = 1; b_if.ovf_clr = 1;
        @(negedge clk);
        b_if.trig_in = 0; b_if.ovf_clr = 0;
        chk("b_clr_lost ovf_cnt", 16'(b_if.ovf_cnt), 16'd1);
        b_if.ovf_clr = 1;
        @(negedge clk);
        b_if.ovf_clr = 0;
        chk("b_clr ovf_cnt", 16'(b_if.ovf_cnt), 16'd0);
        chk("b_clr full", 16'(b_if.full), 16'd1);
        chk("b_clr rd_slot", 16'(b_if.rd_slot), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
